vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel-tick divider, horizontal/vertical counters, and
// registered sync/colour outputs kept pixel-aligned at the connector.
module vga_sync_gen #(
  parameter int unsigned DIV = 2,
  parameter int unsigned HD  = 640,
  parameter int unsigned HF  = 16,
  parameter int unsigned HS  = 96,
  parameter int unsigned HB  = 48,
  parameter int unsigned VD  = 480,
  parameter int unsigned VF  = 10,
  parameter int unsigned VS  = 2,
  parameter int unsigned VB  = 33
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] rgbtext,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       videoon,
  output logic       ptick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       framestart
);

  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(HT - 1);
  localparam logic [9:0]    V_LAST    = 10'(VT - 1);
  localparam logic [9:0]    H_DISP    = 10'(HD);
  localparam logic [9:0]    V_DISP    = 10'(VD);
  localparam logic [9:0]    HS_FIRST  = 10'(HD + HF);
  localparam logic [9:0]    HS_LAST   = 10'(HD + HF + HS - 1);
  localparam logic [9:0]    VS_FIRST  = 10'(VD + VF);
  localparam logic [9:0]    VS_LAST   = 10'(VD + VF + VS - 1);

  logic [TW-1:0] tickcnt;
  logic          line_end;
  logic          frame_end;
  logic [9:0]    x_next;
  logic [9:0]    y_next;
  logic          hsync_next;
  logic          vsync_next;
  logic [2:0]    rgb_next;

  // Clock divider; with DIV=1 the counter sits at zero and every clk is a tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tickcnt <= '0;
    end else if (tickcnt == TICK_LAST) begin
      tickcnt <= '0;
    end else begin
      tickcnt <= tickcnt + TW'(1);
    end
  end

  // Gated by rstn so the tick is quiet during reset even when DIV=1.
  assign ptick   = rstn & (tickcnt == TICK_LAST);
  assign videoon = (pixelx < H_DISP) && (pixely < V_DISP);

  // Next pixel state, all derived from the current (pre-update) coordinate.
  always_comb begin
    line_end   = 1'b0;
    frame_end  = 1'b0;
    x_next     = pixelx;
    y_next     = pixely;
    hsync_next = 1'b1;
    vsync_next = 1'b1;
    rgb_next   = 3'b000;

    line_end  = (pixelx == H_LAST);
    frame_end = line_end && (pixely == V_LAST);

    x_next = line_end ? 10'd0 : pixelx + 10'd1;
    if (line_end) begin
      y_next = (pixely == V_LAST) ? 10'd0 : pixely + 10'd1;
    end

    hsync_next = ~((pixelx >= HS_FIRST) && (pixelx <= HS_LAST));
    vsync_next = ~((pixely >= VS_FIRST) && (pixely <= VS_LAST));
    rgb_next   = videoon ? rgbtext : 3'b000;
  end

  // Pixel-rate registers advance only on ticks; framestart is a one-clk pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pixelx     <= '0;
      pixely     <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= 3'b000;
      framestart <= 1'b0;
    end else begin
      framestart <= ptick && frame_end;
      if (ptick) begin
        pixelx <= x_next;
        pixely <= y_next;
        hsync  <= hsync_next;
        vsync  <= vsync_next;
        rgb    <= rgb_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: full 640x480 timing plus reduced
// geometries at DIV=1,2,3 so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int NI = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    logic       fs;
    logic       von;
  } obs_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int g_div[NI] = '{2, 2, 1, 3};
  int g_hd[NI]  = '{640, 16, 10, 10};
  int g_hf[NI]  = '{16, 2, 3, 3};
  int g_hs[NI]  = '{96, 3, 4, 4};
  int g_hb[NI]  = '{48, 4, 3, 3};
  int g_vd[NI]  = '{480, 8, 6, 6};
  int g_vf[NI]  = '{10, 2, 1, 1};
  int g_vs[NI]  = '{2, 2, 2, 2};
  int g_vb[NI]  = '{33, 3, 2, 2};

  logic [9:0] px[NI];
  logic [9:0] py[NI];
  logic       von[NI];
  logic       pt[NI];
  logic       hs[NI];
  logic       vs[NI];
  logic       fs[NI];
  logic [2:0] rgb[NI];
  logic [2:0] rt[NI];
  logic [2:0] rnd[NI];

  // 0: random colour, 1: pixelx[2:0] pattern, 2: constant white
  int mode = 0;

  obs_t sbq[NI][$];
  int tests = 0;
  int fails = 0;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      rt[i] = (mode == 1) ? px[i][2:0] : (mode == 2) ? 3'b111 : rnd[i];
    end
  end

  vga_sync_gen u0 (
    .clk(clk), .rstn(rstn), .rgbtext(rt[0]), .pixelx(px[0]), .pixely(py[0]),
    .videoon(von[0]), .ptick(pt[0]), .hsync(hs[0]), .vsync(vs[0]), .rgb(rgb[0]),
    .framestart(fs[0]));

  vga_sync_gen #(.DIV(2), .HD(16), .HF(2), .HS(3), .HB(4), .VD(8), .VF(2), .VS(2), .VB(3)) u1 (
    .clk(clk), .rstn(rstn), .rgbtext(rt[1]), .pixelx(px[1]), .pixely(py[1]),
    .videoon(von[1]), .ptick(pt[1]), .hsync(hs[1]), .vsync(vs[1]), .rgb(rgb[1]),
    .framestart(fs[1]));

  vga_sync_gen #(.DIV(1), .HD(10), .HF(3), .HS(4), .HB(3), .VD(6), .VF(1), .VS(2), .VB(2)) u2 (
    .clk(clk), .rstn(rstn), .rgbtext(rt[2]), .pixelx(px[2]), .pixely(py[2]),
    .videoon(von[2]), .ptick(pt[2]), .hsync(hs[2]), .vsync(vs[2]), .rgb(rgb[2]),
    .framestart(fs[2]));

  vga_sync_gen #(.DIV(3), .HD(10), .HF(3), .HS(4), .HB(3), .VD(6), .VF(1), .VS(2), .VB(2)) u3 (
    .clk(clk), .rstn(rstn), .rgbtext(rt[3]), .pixelx(px[3]), .pixely(py[3]),
    .videoon(von[3]), .ptick(pt[3]), .hsync(hs[3]), .vsync(vs[3]), .rgb(rgb[3]),
    .framestart(fs[3]));

  function automatic obs_t reset_obs();
    obs_t r;
    r.x = 10'd0; r.y = 10'd0; r.hs = 1'b1; r.vs = 1'b1;
    r.rgb = 3'b000; r.fs = 1'b0; r.von = 1'b1;
    return r;
  endfunction

  function automatic obs_t actual(input int i);
    obs_t a;
    a.x = px[i]; a.y = py[i]; a.hs = hs[i]; a.vs = vs[i];
    a.rgb = rgb[i]; a.fs = fs[i]; a.von = von[i];
    return a;
  endfunction

  task automatic check(input string name, input int i, input obs_t a, input obs_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s u%0d t=%0t got x=%0d y=%0d hs=%b vs=%b rgb=%b fs=%b von=%b want x=%0d y=%0d hs=%b vs=%b rgb=%b fs=%b von=%b",
               name, i, $time, a.x, a.y, a.hs, a.vs, a.rgb, a.fs, a.von,
               e.x, e.y, e.hs, e.vs, e.rgb, e.fs, e.von);
    end
  endtask

  task automatic check_bit(input string name, input int i, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s u%0d t=%0t got %b want %b", name, i, $time, a, e);
    end
  endtask

  // Reference: pixel n of the frame is column n%HT, line n/HT; one entry per pixel tick.
  task automatic model(input int i);
    int ht, vt, k, n, x, y;
    logic [2:0] text;
    obs_t e;
    ht = g_hd[i] + g_hf[i] + g_hs[i] + g_hb[i];
    vt = g_vd[i] + g_vf[i] + g_vs[i] + g_vb[i];
    k = 0;
    n = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        k = 0;
        n = 0;
        sbq[i].delete();
      end else begin
        k++;
        if (k % g_div[i] == 0) begin
          x = n % ht;
          y = n / ht;
          text = (mode == 1) ? 3'(x % 8) : (mode == 2) ? 3'b111 : rnd[i];
          e.hs  = !(x >= g_hd[i] + g_hf[i] && x < g_hd[i] + g_hf[i] + g_hs[i]);
          e.vs  = !(y >= g_vd[i] + g_vf[i] && y < g_vd[i] + g_vf[i] + g_vs[i]);
          e.rgb = (x < g_hd[i] && y < g_vd[i]) ? text : 3'b000;
          e.fs  = (n == ht * vt - 1);
          n = (n + 1) % (ht * vt);
          e.x   = 10'(n % ht);
          e.y   = 10'(n / ht);
          e.von = ((n % ht) < g_hd[i]) && ((n / ht) < g_vd[i]);
          sbq[i].push_back(e);
        end
      end
    end
  endtask

  // Checks every clk: a fresh entry after each tick edge, held values otherwise.
  task automatic monitor(input int i);
    int j;
    obs_t last, e, a;
    j = 0;
    last = reset_obs();
    forever begin
      @(negedge clk);
      a = actual(i);
      if (!rstn) begin
        j = 0;
        last = reset_obs();
        check("reset_state", i, a, last);
        check_bit("reset_ptick", i, pt[i], 1'b0);
      end else begin
        j++;
        if (j % g_div[i] == 0) begin
          if (sbq[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pixel u%0d t=%0t got an output with no expected entry", i, $time);
          end else begin
            e = sbq[i].pop_front();
            check("pixel", i, a, e);
            last = e;
          end
        end else begin
          last.fs = 1'b0;
          check("hold", i, a, last);
        end
        check_bit("ptick", i, pt[i], ((j + 1) % g_div[i]) == 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) rnd[i] = 3'b000;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NI; i++) rnd[i] = 3'($urandom);
    end
  end

  initial begin
    fork
      model(0); model(1); model(2); model(3);
      monitor(0); monitor(1); monitor(2); monitor(3);
    join_none

    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (4000) @(negedge clk);

    // Asynchronous reset mid-line, checked before the next clk edge.
    #3 rstn = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("async_reset", i, actual(i), reset_obs());
      check_bit("async_reset_ptick", i, pt[i], 1'b0);
    end
    repeat (3) @(negedge clk);
    mode = 1;
    #2 rstn = 1'b1;
    repeat (3000) @(negedge clk);

    #2 mode = 2;
    repeat (5000) @(negedge clk);

    #2;
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (sbq[i].size() != 0) begin
        fails++;
        $display("FAIL drain u%0d got %0d pending entries want 0", i, sbq[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
